phy_rx_deserializer: RTL and testbench
======================================

PHY_RX_DESERIALIZER -- requirements
Module: phy_rx_deserializer

Interface
REQ-001 Parameter COM, default 8'hBC, comma/alignment symbol sent while the transmitter is not yet active.
REQ-002 Parameter IDL, default 8'h7C, idle symbol sent while active with no valid data.
REQ-003 Parameter LOCK_COUNT, default 4, consecutive aligned COM bytes required to declare the link active.
REQ-004 clk_32f  input  1  single clock; serial bit rate.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 data_serial  input  1  serial line; bytes arrive MSB first, one bit per clk_32f edge.
REQ-007 data_out  output  8  recovered data byte.
REQ-008 valid_out  output  1  data_out holds a new data byte this cycle.
REQ-009 byte_strobe  output  1  one-cycle pulse per aligned byte boundary while ACTIVE.
REQ-010 active  output  1  link aligned and active.

Function
REQ-011 data_serial SHALL be sampled on every rising clk_32f edge into an 8-bit shift register, new bit at LSB.
REQ-012 The FSM SHALL have three states: HUNT, SYNC, ACTIVE.
REQ-013 In HUNT, the shift register SHALL be compared with COM on every edge (bit-level search); a match at edge N moves to SYNC, sets the COM count to 1, and places the next byte boundary at edge N+8.
REQ-014 A 3-bit bit counter SHALL mark byte boundaries every 8 edges once out of HUNT, and SHALL wrap 7->0 without gaps.
REQ-015 In SYNC at each boundary: byte == COM increments the COM count; byte != COM returns to HUNT and clears the count.
REQ-016 When the COM count reaches LOCK_COUNT, the FSM SHALL enter ACTIVE; active SHALL assert on the edge after that boundary.
REQ-017 In ACTIVE, byte_strobe SHALL pulse high for one cycle on the edge after each boundary.
REQ-018 In ACTIVE, a byte that is neither COM nor IDL SHALL appear on data_out with valid_out high for one cycle, on the edge after its 8th bit is sampled (latency 1 cycle).
REQ-019 In ACTIVE, a COM or IDL byte SHALL leave valid_out low and data_out at its previous value.
REQ-020 ACTIVE SHALL persist until reset; COM/IDL in ACTIVE SHALL NOT cause loss of lock.
REQ-021 In HUNT and SYNC, valid_out, byte_strobe and active SHALL be 0, and data_out SHALL hold its value.
REQ-022 A COM pattern spanning a boundary in ACTIVE SHALL NOT cause realignment.

Reset
REQ-023 Asserting reset SHALL immediately force: state HUNT, shift register 8'h00, bit counter 0, COM count 0, data_out 8'h00, valid_out 0, byte_strobe 0, active 0.
REQ-024 Reset asserted mid-byte or while ACTIVE SHALL discard partial data; after release, alignment restarts from HUNT.
REQ-025 The first sample SHALL be taken on the first rising clk_32f edge after reset deasserts.

Structure
REQ-026 COM, IDL, LOCK_COUNT defaults and the FSM state encodings SHALL reside in the shared phy package used by the transmit-side parallel-to-serial stage.
REQ-027 The block SHALL be a single module with no sub-modules, with registered outputs only.
REQ-028 The block SHALL be usable as the receive stage after the phy serializer and SHALL synthesize with the team's cmos_cells flow for behavioural-vs-synthesized comparison.

Verification
REQ-029 Reset, then four COM bytes bit-aligned -> active=1 one edge after the 4th COM boundary; valid_out stays 0.
REQ-030 3 random bits, then four COM bytes -> lock achieved at offset 3; subsequent byte 8'h5A -> data_out=8'h5A, valid_out=1 for one cycle.
REQ-031 COM, COM, 8'h12, then four COM -> return to HUNT after 8'h12; active only after the final four COM bytes.
REQ-032 In ACTIVE: 8'hA1, IDL, COM, 8'hFF -> valid_out pulses only for A1 and FF; data_out holds 8'hA1 through IDL/COM; byte_strobe pulses on all four.
REQ-033 Reset asserted 3 bits into a data byte while ACTIVE -> all outputs 0 immediately; four COM bytes after release -> active again.
REQ-034 Behavioural and synthesized netlists driven with identical serial stimulus -> data_out, valid_out, active match cycle-for-cycle.

Source files
------------

// File: rtl/phy_rx_deserializer_pkg.sv
// Shared PHY definitions: control symbols, lock depth and the receive FSM state encoding.
// Used by both the serializer (transmit) and the deserializer (receive) sides of the link.
package phy_rx_deserializer_pkg;

    localparam logic [7:0]  PHY_COM        = 8'hBC;
    localparam logic [7:0]  PHY_IDL        = 8'h7C;
    localparam int unsigned PHY_LOCK_COUNT = 4;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_ACTIVE = 2'd2
    } phy_state_e;

    // COM and IDL carry no payload once the link is active.
    function automatic logic is_ctrl(input logic [7:0] b,
                                     input logic [7:0] com,
                                     input logic [7:0] idl);
        return (b == com) || (b == idl);
    endfunction

endpackage

// File: rtl/phy_rx_deserializer.sv
// Serial-to-parallel receive stage: bit-level COM search, byte-level lock confirmation,
// then byte-aligned payload extraction with a one-cycle output latency.
module phy_rx_deserializer
    import phy_rx_deserializer_pkg::*;
#(
    parameter logic [7:0]  COM        = PHY_COM,
    parameter logic [7:0]  IDL        = PHY_IDL,
    parameter int unsigned LOCK_COUNT = PHY_LOCK_COUNT
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_serial,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       byte_strobe,
    output logic       active
);

    localparam int unsigned    CW        = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
    localparam logic [CW-1:0]  LOCK_LAST = CW'((LOCK_COUNT < 1) ? 0 : LOCK_COUNT - 1);

    phy_state_e    state_q;
    logic [7:0]    shift_q;
    logic [2:0]    bit_cnt_q;
    logic [CW-1:0] com_cnt_q;
    logic [7:0]    data_q;
    logic          valid_q;
    logic          strobe_q;
    logic          active_q;

    logic          boundary;
    logic          com_hit;
    logic          payload;

    // bit_cnt_q counts bits shifted in since the last aligned boundary, so a value of
    // zero means shift_q currently holds exactly one aligned byte.
    assign boundary = (bit_cnt_q == 3'd0);
    assign com_hit  = (shift_q == COM);
    assign payload  = !is_ctrl(shift_q, COM, IDL);

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            state_q   <= ST_HUNT;
            shift_q   <= 8'h00;
            bit_cnt_q <= 3'd0;
            com_cnt_q <= '0;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            strobe_q  <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            shift_q  <= {shift_q[6:0], data_serial};
            valid_q  <= 1'b0;
            strobe_q <= 1'b0;

            case (state_q)
                ST_HUNT: begin
                    bit_cnt_q <= 3'd0;
                    if (com_hit) begin
                        // The bit arriving on this edge is already bit 1 of the next byte.
                        bit_cnt_q <= 3'd1;
                        com_cnt_q <= CW'(1);
                        if (LOCK_COUNT <= 1) begin
                            state_q  <= ST_ACTIVE;
                            active_q <= 1'b1;
                        end else begin
                            state_q <= ST_SYNC;
                        end
                    end
                end

                ST_SYNC: begin
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (boundary) begin
                        if (com_hit) begin
                            com_cnt_q <= com_cnt_q + CW'(1);
                            if (com_cnt_q == LOCK_LAST) begin
                                state_q  <= ST_ACTIVE;
                                active_q <= 1'b1;
                            end
                        end else begin
                            state_q   <= ST_HUNT;
                            com_cnt_q <= '0;
                            bit_cnt_q <= 3'd0;
                        end
                    end
                end

                ST_ACTIVE: begin
                    // Alignment is frozen here; only reset restarts the search.
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (boundary) begin
                        strobe_q <= 1'b1;
                        if (payload) begin
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
                        end
                    end
                end

                default: begin
                    state_q   <= ST_HUNT;
                    bit_cnt_q <= 3'd0;
                    com_cnt_q <= '0;
                    active_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data_out    = data_q;
    assign valid_out   = valid_q;
    assign byte_strobe = strobe_q;
    assign active      = active_q;

endmodule

// File: tb/tb_phy_rx_deserializer.sv
// Self-checking bench for phy_rx_deserializer: serial stimulus with a scoreboard of
// expected valid/strobe events keyed by clock edge number.
module tb_phy_rx_deserializer;

    localparam logic [7:0] COM_B = 8'hBC;
    localparam logic [7:0] IDL_B = 8'h7C;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       data_serial = 1'b0;
    logic [7:0] data_out;
    logic       valid_out;
    logic       byte_strobe;
    logic       active;

    phy_rx_deserializer dut (
        .clk_32f     (clk),
        .reset       (reset),
        .data_serial (data_serial),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .byte_strobe (byte_strobe),
        .active      (active)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         e;
        logic [7:0] d;
    } obs_t;

    typedef struct {
        int         e;
        logic [7:0] d;
        logic       v;
    } stb_t;

    int   errors = 0;
    int   checks = 0;
    int   edge_cnt = 0;
    int   last_edge = 0;
    int   vrd = 0;
    int   srd = 0;
    int   ard = 0;
    logic [7:0] exp_data = 8'h00;
    logic active_prev = 1'b0;

    obs_t valid_obs[$];
    stb_t strobe_obs[$];
    int   active_rise[$];
    obs_t exp_valid[$];
    stb_t exp_strobe[$];

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Monitor: outputs seen at a negedge were produced by posedge number edge_cnt.
    always @(negedge clk) begin
        if (valid_out === 1'b1) valid_obs.push_back('{edge_cnt, data_out});
        if (byte_strobe === 1'b1) strobe_obs.push_back('{edge_cnt, data_out, valid_out});
        if (active === 1'b1 && active_prev !== 1'b1) active_rise.push_back(edge_cnt);
        active_prev <= active;
    end

    task automatic send_bit(input logic b);
        @(negedge clk);
        data_serial = b;
        last_edge = edge_cnt + 1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit expect_out);
        logic pay;
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        if (expect_out) begin
            pay = (b != COM_B) && (b != IDL_B);
            if (pay) begin
                exp_data = b;
                exp_valid.push_back('{last_edge + 1, b});
            end
            exp_strobe.push_back('{last_edge + 1, exp_data, pay});
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        data_serial = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_data = 8'h00;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset data_out: got %h required 00", data_out); end
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset valid_out: got %b required 0", valid_out); end
        checks++; if (byte_strobe !== 1'b0) begin errors++; $display("FAIL reset byte_strobe: got %b required 0", byte_strobe); end
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL reset active: got %b required 0", active); end
        $display("test_reset done");
    endtask

    task automatic test_aligned_lock();
        int exp_rise;
        obs_t ev;
        stb_t es;
        do_reset();
        for (int k = 0; k < 4; k++) send_byte(COM_B, 1'b0);
        exp_rise = last_edge + 1;
        send_byte(IDL_B, 1'b1);
        send_byte(COM_B, 1'b1);
        repeat (3) @(negedge clk);
        checks++;
        if (active_rise.size() - ard != 1) begin errors++; $display("FAIL aligned active rises: got %0d required 1", active_rise.size() - ard); end
        else if (active_rise[ard] != exp_rise) begin errors++; checks++; $display("FAIL aligned active edge: got %0d required %0d", active_rise[ard], exp_rise); end
        else checks++;
        ard = active_rise.size();
        while (exp_valid.size() > 0) begin
            ev = exp_valid.pop_front(); checks++;
            if (vrd >= valid_obs.size()) begin errors++; $display("FAIL aligned valid: missing pulse, required %h at edge %0d", ev.d, ev.e); end
            else begin
                if (valid_obs[vrd].e != ev.e || valid_obs[vrd].d !== ev.d) begin errors++; $display("FAIL aligned valid: got %h at edge %0d required %h at edge %0d", valid_obs[vrd].d, valid_obs[vrd].e, ev.d, ev.e); end
                vrd++;
            end
        end
        checks++; if (vrd != valid_obs.size()) begin errors++; $display("FAIL aligned valid count: got %0d extra pulses required 0", valid_obs.size() - vrd); vrd = valid_obs.size(); end
        while (exp_strobe.size() > 0) begin
            es = exp_strobe.pop_front(); checks++;
            if (srd >= strobe_obs.size()) begin errors++; $display("FAIL aligned strobe: missing pulse at edge %0d", es.e); end
            else begin
                if (strobe_obs[srd].e != es.e || strobe_obs[srd].d !== es.d || strobe_obs[srd].v !== es.v) begin errors++; $display("FAIL aligned strobe: got edge %0d data %h valid %b required edge %0d data %h valid %b", strobe_obs[srd].e, strobe_obs[srd].d, strobe_obs[srd].v, es.e, es.d, es.v); end
                srd++;
            end
        end
        checks++; if (srd != strobe_obs.size()) begin errors++; $display("FAIL aligned strobe count: got %0d extra pulses required 0", strobe_obs.size() - srd); srd = strobe_obs.size(); end
        $display("test_aligned_lock done, lock edge %0d", exp_rise);
    endtask

    task automatic test_offset_lock();
        int exp_rise;
        obs_t ev;
        stb_t es;
        do_reset();
        for (int k = 0; k < 3; k++) send_bit(1'($urandom_range(0, 1)));
        for (int k = 0; k < 4; k++) send_byte(COM_B, 1'b0);
        exp_rise = last_edge + 1;
        send_byte(8'h5A, 1'b1);
        send_byte(IDL_B, 1'b1);
        repeat (3) @(negedge clk);
        checks++;
        if (active_rise.size() - ard != 1) begin errors++; $display("FAIL offset active rises: got %0d required 1", active_rise.size() - ard); end
        else if (active_rise[ard] != exp_rise) begin errors++; checks++; $display("FAIL offset active edge: got %0d required %0d", active_rise[ard], exp_rise); end
        else checks++;
        ard = active_rise.size();
        while (exp_valid.size() > 0) begin
            ev = exp_valid.pop_front(); checks++;
            if (vrd >= valid_obs.size()) begin errors++; $display("FAIL offset valid: missing pulse, required %h at edge %0d", ev.d, ev.e); end
            else begin
                if (valid_obs[vrd].e != ev.e || valid_obs[vrd].d !== ev.d) begin errors++; $display("FAIL offset valid: got %h at edge %0d required %h at edge %0d", valid_obs[vrd].d, valid_obs[vrd].e, ev.d, ev.e); end
                vrd++;
            end
        end
        checks++; if (vrd != valid_obs.size()) begin errors++; $display("FAIL offset valid count: got %0d extra pulses required 0", valid_obs.size() - vrd); vrd = valid_obs.size(); end
        while (exp_strobe.size() > 0) begin
            es = exp_strobe.pop_front(); checks++;
            if (srd >= strobe_obs.size()) begin errors++; $display("FAIL offset strobe: missing pulse at edge %0d", es.e); end
            else begin
                if (strobe_obs[srd].e != es.e || strobe_obs[srd].d !== es.d || strobe_obs[srd].v !== es.v) begin errors++; $display("FAIL offset strobe: got edge %0d data %h valid %b required edge %0d data %h valid %b", strobe_obs[srd].e, strobe_obs[srd].d, strobe_obs[srd].v, es.e, es.d, es.v); end
                srd++;
            end
        end
        checks++; if (srd != strobe_obs.size()) begin errors++; $display("FAIL offset strobe count: got %0d extra pulses required 0", strobe_obs.size() - srd); srd = strobe_obs.size(); end
        $display("test_offset_lock done, lock edge %0d", exp_rise);
    endtask

    task automatic test_false_sync();
        int exp_rise;
        logic [7:0] seq [7];
        seq = '{COM_B, COM_B, 8'h12, COM_B, COM_B, COM_B, COM_B};
        do_reset();
        for (int k = 0; k < 7; k++) send_byte(seq[k], 1'b0);
        exp_rise = last_edge + 1;
        send_byte(8'h3E, 1'b1);
        repeat (3) @(negedge clk);
        checks++;
        if (active_rise.size() - ard != 1) begin errors++; $display("FAIL false_sync active rises: got %0d required 1", active_rise.size() - ard); end
        else if (active_rise[ard] != exp_rise) begin errors++; checks++; $display("FAIL false_sync active edge: got %0d required %0d", active_rise[ard], exp_rise); end
        else checks++;
        ard = active_rise.size();
        checks++;
        if (valid_obs.size() - vrd != 1) begin errors++; $display("FAIL false_sync valid count: got %0d required 1", valid_obs.size() - vrd); end
        else if (valid_obs[vrd].d !== 8'h3E || valid_obs[vrd].e != exp_valid[0].e) begin errors++; $display("FAIL false_sync valid: got %h at edge %0d required 3e at edge %0d", valid_obs[vrd].d, valid_obs[vrd].e, exp_valid[0].e); end
        checks++;
        if (strobe_obs.size() - srd != 1) begin errors++; $display("FAIL false_sync strobe count: got %0d required 1", strobe_obs.size() - srd); end
        else if (strobe_obs[srd].e != exp_strobe[0].e) begin errors++; $display("FAIL false_sync strobe edge: got %0d required %0d", strobe_obs[srd].e, exp_strobe[0].e); end
        vrd = valid_obs.size();
        srd = strobe_obs.size();
        exp_valid.delete();
        exp_strobe.delete();
        $display("test_false_sync done, lock edge %0d", exp_rise);
    endtask

    task automatic test_data_mix();
        obs_t ev;
        stb_t es;
        logic [7:0] seq [5];
        seq = '{8'hA1, IDL_B, COM_B, 8'hFF, IDL_B};
        do_reset();
        for (int k = 0; k < 4; k++) send_byte(COM_B, 1'b0);
        for (int k = 0; k < 5; k++) send_byte(seq[k], 1'b1);
        repeat (3) @(negedge clk);
        ard = active_rise.size();
        while (exp_valid.size() > 0) begin
            ev = exp_valid.pop_front(); checks++;
            if (vrd >= valid_obs.size()) begin errors++; $display("FAIL mix valid: missing pulse, required %h at edge %0d", ev.d, ev.e); end
            else begin
                if (valid_obs[vrd].e != ev.e || valid_obs[vrd].d !== ev.d) begin errors++; $display("FAIL mix valid: got %h at edge %0d required %h at edge %0d", valid_obs[vrd].d, valid_obs[vrd].e, ev.d, ev.e); end
                vrd++;
            end
        end
        checks++; if (vrd != valid_obs.size()) begin errors++; $display("FAIL mix valid count: got %0d extra pulses required 0", valid_obs.size() - vrd); vrd = valid_obs.size(); end
        while (exp_strobe.size() > 0) begin
            es = exp_strobe.pop_front(); checks++;
            if (srd >= strobe_obs.size()) begin errors++; $display("FAIL mix strobe: missing pulse at edge %0d", es.e); end
            else begin
                if (strobe_obs[srd].e != es.e || strobe_obs[srd].d !== es.d || strobe_obs[srd].v !== es.v) begin errors++; $display("FAIL mix strobe: got edge %0d data %h valid %b required edge %0d data %h valid %b", strobe_obs[srd].e, strobe_obs[srd].d, strobe_obs[srd].v, es.e, es.d, es.v); end
                srd++;
            end
        end
        checks++; if (srd != strobe_obs.size()) begin errors++; $display("FAIL mix strobe count: got %0d extra pulses required 0", strobe_obs.size() - srd); srd = strobe_obs.size(); end
        checks++; if (active !== 1'b1) begin errors++; $display("FAIL mix active after COM/IDL: got %b required 1", active); end
        $display("test_data_mix done");
    endtask

    task automatic test_reset_active();
        int exp_rise;
        obs_t ev;
        stb_t es;
        logic [7:0] partial;
        partial = 8'h81;
        do_reset();
        for (int k = 0; k < 4; k++) send_byte(COM_B, 1'b0);
        send_byte(8'h3C, 1'b1);
        send_byte(IDL_B, 1'b1);
        for (int i = 7; i >= 5; i--) send_bit(partial[i]);
        @(posedge clk);
        #2;
        checks++; if (active !== 1'b1 || data_out !== 8'h3C) begin errors++; $display("FAIL pre-reset state: got active=%b data_out=%h required active=1 data_out=3c", active, data_out); end
        reset = 1'b1;
        #1;
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL async reset data_out: got %h required 00", data_out); end
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL async reset valid_out: got %b required 0", valid_out); end
        checks++; if (byte_strobe !== 1'b0) begin errors++; $display("FAIL async reset byte_strobe: got %b required 0", byte_strobe); end
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL async reset active: got %b required 0", active); end
        ard = active_rise.size();
        @(negedge clk);
        reset = 1'b0;
        exp_data = 8'h00;
        for (int k = 0; k < 4; k++) send_byte(COM_B, 1'b0);
        exp_rise = last_edge + 1;
        send_byte(8'h99, 1'b1);
        send_byte(IDL_B, 1'b1);
        repeat (3) @(negedge clk);
        checks++;
        if (active_rise.size() - ard != 1) begin errors++; $display("FAIL relock active rises: got %0d required 1", active_rise.size() - ard); end
        else if (active_rise[ard] != exp_rise) begin errors++; checks++; $display("FAIL relock active edge: got %0d required %0d", active_rise[ard], exp_rise); end
        else checks++;
        ard = active_rise.size();
        while (exp_valid.size() > 0) begin
            ev = exp_valid.pop_front(); checks++;
            if (vrd >= valid_obs.size()) begin errors++; $display("FAIL relock valid: missing pulse, required %h at edge %0d", ev.d, ev.e); end
            else begin
                if (valid_obs[vrd].e != ev.e || valid_obs[vrd].d !== ev.d) begin errors++; $display("FAIL relock valid: got %h at edge %0d required %h at edge %0d", valid_obs[vrd].d, valid_obs[vrd].e, ev.d, ev.e); end
                vrd++;
            end
        end
        checks++; if (vrd != valid_obs.size()) begin errors++; $display("FAIL relock valid count: got %0d extra pulses required 0", valid_obs.size() - vrd); vrd = valid_obs.size(); end
        while (exp_strobe.size() > 0) begin
            es = exp_strobe.pop_front(); checks++;
            if (srd >= strobe_obs.size()) begin errors++; $display("FAIL relock strobe: missing pulse at edge %0d", es.e); end
            else begin
                if (strobe_obs[srd].e != es.e || strobe_obs[srd].d !== es.d || strobe_obs[srd].v !== es.v) begin errors++; $display("FAIL relock strobe: got edge %0d data %h valid %b required edge %0d data %h valid %b", strobe_obs[srd].e, strobe_obs[srd].d, strobe_obs[srd].v, es.e, es.d, es.v); end
                srd++;
            end
        end
        checks++; if (srd != strobe_obs.size()) begin errors++; $display("FAIL relock strobe count: got %0d extra pulses required 0", strobe_obs.size() - srd); srd = strobe_obs.size(); end
        $display("test_reset_active done, relock edge %0d", exp_rise);
    endtask

    initial begin
        test_reset();
        test_aligned_lock();
        test_offset_lock();
        test_false_sync();
        test_data_mix();
        test_reset_active();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
